// File: rtl/softmax_exp_pkg.sv
// Shared types and constants for the softmax exponential scheduler.
// The scheduler FSM encoding and the bfloat16/CORDIC timing constants live here.
package softmax_exp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_RESP
  } sched_state_e;

  localparam int BF16_W      = 16;
  localparam int CORDIC_LAT  = 20;
  // The timeout must cover a full CORDIC run plus the capture cycle.
  localparam int DEF_TIMEOUT = 24;

endpackage

// File: rtl/cordic_exp_sched_if.sv
// Request/response bundle between the softmax lanes and the exp scheduler.
// The scheduler uses the slave view; the lane controllers use the master view.
interface cordic_exp_sched_if
  import softmax_exp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][BF16_W-1:0] req_z;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           resp_valid;
  logic                           resp_ready;
  logic [ID_W-1:0]                resp_id;
  logic [BF16_W-1:0]              resp_data;
  logic                           resp_err;

  modport slave (
    input  req_valid, req_z, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport master (
    output req_valid, req_z, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

endinterface

// File: rtl/cordic_exp_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping at N; returns a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      idx = sum[IDX_W-1:0];
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_exp_sched.sv
// Round-robin scheduler sharing one bfloat16 CORDIC exp unit among NUM_REQ
// softmax lanes; returns each result tagged with the requesting lane index.
module cordic_exp_sched
  import softmax_exp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  cordic_exp_sched_if.slave   bus,
  output logic                cordic_en,
  output logic [BF16_W-1:0]   cordic_z,
  input  logic [BF16_W-1:0]   cordic_out,
  input  logic                cordic_done
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  sched_state_e         state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, gnt_idx, id_q, ptr_nxt;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_any, hs, tmo_hit;
  logic [BF16_W-1:0]    z_q, data_q;
  logic                 err_q, en_q;
  logic [TMO_W-1:0]     tmo_cnt;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Grants are offered only in IDLE and are suppressed while reset is held.
  assign bus.req_ready = (state == S_IDLE && rst_n) ? gnt : '0;
  assign hs            = (state == S_IDLE) && gnt_any;
  assign tmo_hit       = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign ptr_nxt       = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (hs) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_BUSY;
      S_BUSY:   if (cordic_done || tmo_hit) state_nxt = S_RESP;
      S_RESP:   if (bus.resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // cordic_done is only looked at in BUSY; its idle-high level elsewhere is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      id_q    <= '0;
      z_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      en_q <= hs;
      case (state)
        S_IDLE: begin
          if (hs) begin
            z_q    <= bus.req_z[gnt_idx];
            id_q   <= gnt_idx;
            rr_ptr <= ptr_nxt;
          end
        end
        S_LAUNCH: tmo_cnt <= '0;
        S_BUSY: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (cordic_done) begin
            data_q <= cordic_out;
            err_q  <= 1'b0;
          end else if (tmo_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cordic_en      = en_q;
  assign cordic_z       = z_q;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_cordic_exp_sched.sv
// Directed bench for cordic_exp_sched with a behavioural 20-cycle CORDIC exp model.
module tb_cordic_exp_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cordic_en;
  logic [15:0] cordic_z;
  logic [15:0] cordic_out;
  logic        cordic_done;

  cordic_exp_sched_if #(.NUM_REQ(4)) bus ();

  cordic_exp_sched #(.NUM_REQ(4), .TIMEOUT(24)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cordic_en   (cordic_en),
    .cordic_z    (cordic_z),
    .cordic_out  (cordic_out),
    .cordic_done (cordic_done)
  );

  always #5 clk = ~clk;

  // Exp unit model: never reset; done is high whenever it is idle.
  logic        busy = 1'b0;
  logic [4:0]  steps = '0;
  logic [15:0] z_lat = '0;
  logic [15:0] mdl_out = '0;
  logic        stuck_low = 1'b0;

  function automatic logic [15:0] exp_fn(input logic [15:0] z);
    case (z)
      16'h0000: return 16'h3F80;
      16'h3F80: return 16'h402E;
      16'hBF80: return 16'h3EBC;
      16'h4000: return 16'h40EC;
      default:  return z ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cordic_en) begin
      busy    <= 1'b1;
      steps   <= 5'd18;
      z_lat   <= cordic_z;
      mdl_out <= 16'hDEAD;
    end else if (busy) begin
      if (steps == 5'd0) begin
        busy    <= 1'b0;
        mdl_out <= exp_fn(z_lat);
      end else begin
        steps <= steps - 5'd1;
      end
    end
  end

  assign cordic_done = stuck_low ? 1'b0 : !busy;
  assign cordic_out  = mdl_out;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one request on a single lane; return cycles from handshake cycle to resp_valid.
  task automatic run_job(input logic [1:0] lane, input logic [15:0] z, input string tag,
                         output int cyc);
    bus.req_z[lane] = z;
    bus.req_valid   = 4'b0001 << lane;
    #1;
    chk({tag, "_grant"}, 32'(bus.req_ready), 32'(4'b0001 << lane));
    tick();
    bus.req_valid = '0;
    chk({tag, "_en"}, 32'(cordic_en), 32'd1);
    chk({tag, "_z"}, 32'(cordic_z), 32'(z));
    cyc = 1;
    tick();
    cyc = 2;
    chk({tag, "_early"}, 32'(bus.resp_valid), 32'd0);
    while (!bus.resp_valid && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] lane_res(input int i);
    case (i)
      0: return 16'h402E;
      1: return 16'h3EBC;
      2: return 16'h3F80;
      default: return 16'h40EC;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int cyc;
    int ng, nr, c, nresp;
    int g_idx[5];
    int g_cyc[5];
    int r_id[4];
    logic [15:0] r_data[4];

    // Reset state, with all lanes requesting
    rst_n          = 1'b0;
    bus.req_valid  = 4'hF;
    bus.req_z[0]   = 16'h3F80;
    bus.req_z[1]   = 16'hBF80;
    bus.req_z[2]   = 16'h0000;
    bus.req_z[3]   = 16'h4000;
    bus.resp_ready = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_cordic_en", 32'(cordic_en), 32'd0);
    chk("rst_cordic_z", 32'(cordic_z), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single request on lane 2, z=0.0; stale done high in IDLE/LAUNCH
    run_job(2'd2, 16'h0000, "single", cyc);
    chk("single_latency", 32'(cyc), 32'd22);
    chk("single_id", 32'(bus.resp_id), 32'd2);
    chk("single_data", 32'(bus.resp_data), 32'h3F80);
    chk("single_err", 32'(bus.resp_err), 32'd0);
    tick();
    chk("single_done", 32'(bus.resp_valid), 32'd0);

    // All lanes valid, resp_ready high: round-robin order and 23-cycle cadence
    do_reset();
    bus.req_z[2]  = 16'h0000;
    bus.req_valid = 4'hF;
    #1;
    ng = 0;
    nr = 0;
    for (c = 0; c < 96; c++) begin
      if (ng < 5 && |(bus.req_valid & bus.req_ready)) begin
        g_idx[ng] = onehot_idx(bus.req_ready);
        g_cyc[ng] = c;
        ng++;
      end
      if (nr < 4 && bus.resp_valid && bus.resp_ready) begin
        r_id[nr]   = int'(bus.resp_id);
        r_data[nr] = bus.resp_data;
        nr++;
      end
      tick();
    end
    chk("tp_ngrant", 32'(ng), 32'd5);
    chk("tp_nresp", 32'(nr), 32'd4);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("tp_grant%0d", k), 32'(g_idx[k]), 32'(k % 4));
      if (k > 0) chk($sformatf("tp_gap%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 32'd23);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tp_rid%0d", k), 32'(r_id[k]), 32'(k));
      chk($sformatf("tp_rdata%0d", k), 32'(r_data[k]), 32'(lane_res(k)));
    end

    // resp_ready held low: outputs stable, no new grant, next grant right after acceptance
    do_reset();
    bus.resp_ready = 1'b0;
    run_job(2'd1, 16'hBF80, "hold", cyc);
    chk("hold_latency", 32'(cyc), 32'd22);
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_id", 32'(bus.resp_id), 32'd1);
      chk("hold_data", 32'(bus.resp_data), 32'h3EBC);
      chk("hold_no_grant", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("hold_released", 32'(bus.resp_valid), 32'd0);
    chk("hold_next_grant", 32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = '0;
    chk("hold_next_en", 32'(cordic_en), 32'd1);
    chk("hold_next_z", 32'(cordic_z), 32'h4000);
    cyc = 1;
    while (!bus.resp_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("hold_next_latency", 32'(cyc), 32'd22);
    chk("hold_next_id", 32'(bus.resp_id), 32'd3);
    chk("hold_next_data", 32'(bus.resp_data), 32'h40EC);
    tick();

    // Done stuck low: timeout abort
    do_reset();
    stuck_low = 1'b1;
    run_job(2'd0, 16'h3F80, "tmo", cyc);
    chk("tmo_latency", 32'(cyc), 32'd26);
    chk("tmo_err", 32'(bus.resp_err), 32'd1);
    chk("tmo_data", 32'(bus.resp_data), 32'd0);
    chk("tmo_id", 32'(bus.resp_id), 32'd0);
    tick();
    stuck_low = 1'b0;
    tick();

    // Reset pulsed mid-job: async clear, no response, then a clean job
    do_reset();
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("arst_cordic_z", 32'(cordic_z), 32'd0);
    chk("arst_cordic_en", 32'(cordic_en), 32'd0);
    chk("arst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("arst_resp_data", 32'(bus.resp_data), 32'd0);
    chk("arst_resp_err", 32'(bus.resp_err), 32'd0);
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    nresp = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.resp_valid) nresp++;
      tick();
    end
    chk("arst_no_resp", 32'(nresp), 32'd0);
    run_job(2'd2, 16'h0000, "post", cyc);
    chk("post_latency", 32'(cyc), 32'd22);
    chk("post_id", 32'(bus.resp_id), 32'd2);
    chk("post_data", 32'(bus.resp_data), 32'h3F80);
    chk("post_err", 32'(bus.resp_err), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
